// File: rtl/wb_pkg.sv
// Shared widths and the queued writeback entry type for the writeback queue.
package wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_queue_if.sv
// Producer handshakes (ALU, load) and register-file write port of the writeback queue.
interface writeback_queue_if;
    import wb_pkg::*;

    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_data;
    logic                  alu_ready;

    logic                  mem_valid;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic [XLEN-1:0]       mem_data;
    logic                  mem_ready;

    logic                  rf_stall;
    logic                  we_RF;
    logic [REG_ADDR_W-1:0] A3;
    logic [XLEN-1:0]       WD3;

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output mem_valid, mem_rd, mem_data,
        input  mem_ready,
        output rf_stall,
        input  we_RF, A3, WD3
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  mem_valid, mem_rd, mem_data,
        output mem_ready,
        input  rf_stall,
        output we_RF, A3, WD3
    );

endinterface

// File: rtl/wb_fifo.sv
// Circular FIFO of writeback entries accepting up to two pushes (a before b) and one pop per cycle.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_a,
    input  wb_entry_t             entry_a,
    input  logic                  push_b,
    input  wb_entry_t             entry_b,
    input  logic                  pop,
    output wb_entry_t             head_entry,
    output logic [CNT_W-1:0]      count,
    output logic [PTR_W-1:0]      head,
    output wb_entry_t [DEPTH-1:0] entries
);

    wb_entry_t [DEPTH-1:0] store;
    logic [PTR_W-1:0]      tail;
    logic [PTR_W-1:0]      tail_b;
    logic [CNT_W-1:0]      push_n;
    logic                  pop_ok;

    assign push_n = CNT_W'(push_a) + CNT_W'(push_b);
    assign pop_ok = pop && (count != '0);
    assign tail_b = push_a ? tail + PTR_W'(1) : tail;

    always_ff @(posedge clk) begin
        if (push_a) begin
            store[tail] <= entry_a;
        end
        if (push_b) begin
            store[tail_b] <= entry_b;
        end
    end

    // Pointers rely on natural wrap since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pop_ok);
            tail  <= tail + PTR_W'(push_n);
            count <= count + push_n - CNT_W'(pop_ok);
        end
    end

    assign head_entry = (count != '0) ? store[head] : '0;
    assign entries    = store;

endmodule

// File: rtl/writeback_queue.sv
// Writeback queue: arbitrates ALU/load results into a FIFO drained to the register file.
// Define WB_BYPASS_EN to enable the pending-write lookup on byp_*; otherwise those outputs are 0.
module writeback_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    writeback_queue_if.slave        bus,
    output logic [$clog2(DEPTH):0]  count,
    input  logic [REG_ADDR_W-1:0]   byp_addr1,
    input  logic [REG_ADDR_W-1:0]   byp_addr2,
    output logic                    byp_hit1,
    output logic                    byp_hit2,
    output logic [XLEN-1:0]         byp_data1,
    output logic [XLEN-1:0]         byp_data2
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] ROOM_ONE = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] ROOM_TWO = CNT_W'(DEPTH - 2);

    logic                  push_mem;
    logic                  push_alu;
    wb_entry_t             mem_entry;
    wb_entry_t             alu_entry;
    wb_entry_t             head_entry;
    logic [PTR_W-1:0]      head;
    wb_entry_t [DEPTH-1:0] entries;

    // Ready looks only at registered occupancy, reserving a slot for the load when both offer.
    assign bus.mem_ready = (count <= ROOM_ONE);
    assign bus.alu_ready = bus.mem_valid ? (count <= ROOM_TWO) : (count <= ROOM_ONE);

    assign push_mem  = bus.mem_valid && bus.mem_ready && (bus.mem_rd != '0);
    assign push_alu  = bus.alu_valid && bus.alu_ready && (bus.alu_rd != '0);
    assign mem_entry = '{rd: bus.mem_rd, data: bus.mem_data};
    assign alu_entry = '{rd: bus.alu_rd, data: bus.alu_data};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_a     (push_mem),
        .entry_a    (mem_entry),
        .push_b     (push_alu),
        .entry_b    (alu_entry),
        .pop        (bus.we_RF),
        .head_entry (head_entry),
        .count      (count),
        .head       (head),
        .entries    (entries)
    );

    assign bus.we_RF = (count != '0) && !bus.rf_stall;
    assign bus.A3    = head_entry.rd;
    assign bus.WD3   = head_entry.data;

`ifdef WB_BYPASS_EN
    // Scan oldest to youngest so the last match wins.
    always_comb begin
        byp_hit1  = 1'b0;
        byp_hit2  = 1'b0;
        byp_data1 = '0;
        byp_data2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count) begin
                if ((byp_addr1 != '0) && (entries[head + PTR_W'(i)].rd == byp_addr1)) begin
                    byp_hit1  = 1'b1;
                    byp_data1 = entries[head + PTR_W'(i)].data;
                end
                if ((byp_addr2 != '0) && (entries[head + PTR_W'(i)].rd == byp_addr2)) begin
                    byp_hit2  = 1'b1;
                    byp_data2 = entries[head + PTR_W'(i)].data;
                end
            end
        end
    end
`else
    logic unused_byp;
    assign unused_byp = ^{byp_addr1, byp_addr2, head, entries};
    assign byp_hit1   = 1'b0;
    assign byp_hit2   = 1'b0;
    assign byp_data1  = '0;
    assign byp_data2  = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Directed testbench for writeback_queue with a scoreboard-checked register-file write monitor.
module tb_writeback_queue;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  count;
    logic [4:0]  byp_addr1 = '0;
    logic [4:0]  byp_addr2 = '0;
    logic        byp_hit1;
    logic        byp_hit2;
    logic [31:0] byp_data1;
    logic [31:0] byp_data2;

    int checks = 0;
    int errors = 0;
    wb_entry_t sb[$];
    wb_entry_t exp_e;

    writeback_queue_if bus();

    writeback_queue #(
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .count     (count),
        .byp_addr1 (byp_addr1),
        .byp_addr2 (byp_addr2),
        .byp_hit1  (byp_hit1),
        .byp_hit2  (byp_hit2),
        .byp_data1 (byp_data1),
        .byp_data2 (byp_data2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                                 input logic av, input logic [4:0] ard, input logic [31:0] ad);
        bus.mem_valid = mv;
        bus.mem_rd    = mrd;
        bus.mem_data  = md;
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = ad;
    endtask

    task automatic expectWrite(input logic [4:0] rd, input logic [31:0] d);
        wb_entry_t e;
        e.rd   = rd;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic waitDrain(input string name, input int max_cycles);
        int n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        checkOutput(name, sb.size(), 0);
    endtask

    // Every register-file write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.we_RF === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL rf_write: got write rd=%0d data=0x%08h, expected no write",
                         bus.A3, bus.WD3);
            end else begin
                exp_e = sb.pop_front();
                if (bus.A3 !== exp_e.rd || bus.WD3 !== exp_e.data) begin
                    errors++;
                    $display("[TB] FAIL rf_write: got rd=%0d data=0x%08h, expected rd=%0d data=0x%08h",
                             bus.A3, bus.WD3, exp_e.rd, exp_e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(0, 0, 0, 0, 0, 0);
        bus.rf_stall = 1'b0;
        byp_addr1    = 5'd7;

        // Reset values
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_count", count, 0);
        checkOutput("rst_we", bus.we_RF, 0);
        checkOutput("rst_A3", bus.A3, 0);
        checkOutput("rst_WD3", bus.WD3, 0);
        checkOutput("rst_alu_ready", bus.alu_ready, 1);
        checkOutput("rst_mem_ready", bus.mem_ready, 1);
        checkOutput("rst_byp_hit1", byp_hit1, 0);
        checkOutput("rst_byp_data1", byp_data1, 0);
        tick();
        rst       = 1'b0;
        byp_addr1 = 5'd0;
        tick();

        // Single ALU push, one-cycle latency
        applyStimulus(0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
        checkOutput("single_alu_ready", bus.alu_ready, 1);
        expectWrite(5'd5, 32'hDEADBEEF);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("single_count_1", count, 1);
        checkOutput("single_we", bus.we_RF, 1);
        tick();
        checkOutput("single_count_0", count, 0);

        // Same-cycle mem and alu: mem first
        applyStimulus(1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
        checkOutput("dual_mem_ready", bus.mem_ready, 1);
        checkOutput("dual_alu_ready", bus.alu_ready, 1);
        expectWrite(5'd3, 32'h11);
        expectWrite(5'd4, 32'h22);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("dual_count", count, 2);
        waitDrain("dual_drained", 10);
        checkOutput("dual_count_end", count, 0);

        // Fill under stall, including the count=DEPTH-1 boundary with both offering
        bus.rf_stall = 1'b1;
        applyStimulus(1, 5'd1, 32'h101, 1, 5'd2, 32'h102);
        expectWrite(5'd1, 32'h101);
        expectWrite(5'd2, 32'h102);
        tick();
        applyStimulus(1, 5'd6, 32'h106, 0, 0, 0);
        expectWrite(5'd6, 32'h106);
        tick();
        checkOutput("fill_count_3", count, 3);
        applyStimulus(1, 5'd9, 32'h109, 1, 5'd12, 32'h10C);
        checkOutput("fill3_mem_ready", bus.mem_ready, 1);
        checkOutput("fill3_alu_ready", bus.alu_ready, 0);
        expectWrite(5'd9, 32'h109);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("full_count", count, 4);
        checkOutput("full_mem_ready", bus.mem_ready, 0);
        checkOutput("full_alu_ready", bus.alu_ready, 0);
        checkOutput("full_stall_we", bus.we_RF, 0);
        applyStimulus(1, 5'd20, 32'h200, 1, 5'd21, 32'h201);
        checkOutput("full_mem_ready_offer", bus.mem_ready, 0);
        checkOutput("full_alu_ready_offer", bus.alu_ready, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("full_count_hold", count, 4);
        bus.rf_stall = 1'b0;
        waitDrain("full_drained", 20);
        checkOutput("full_count_end", count, 0);

        // rd = 0 handshakes but never queues
        applyStimulus(1, 5'd0, 32'h66, 1, 5'd0, 32'h55);
        checkOutput("x0_mem_ready", bus.mem_ready, 1);
        checkOutput("x0_alu_ready", bus.alu_ready, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("x0_count", count, 0);
        checkOutput("x0_we", bus.we_RF, 0);
        tick();
        tick();
        checkOutput("x0_count_later", count, 0);

        // Bypass lookup with two pending writes to the same register
        bus.rf_stall = 1'b1;
        applyStimulus(0, 0, 0, 1, 5'd7, 32'h1);
        expectWrite(5'd7, 32'h1);
        tick();
        applyStimulus(0, 0, 0, 1, 5'd7, 32'h2);
        expectWrite(5'd7, 32'h2);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        byp_addr1 = 5'd7;
        byp_addr2 = 5'd0;
        #1;
`ifdef WB_BYPASS_EN
        checkOutput("byp_hit1", byp_hit1, 1);
        checkOutput("byp_data1", byp_data1, 32'h2);
`else
        checkOutput("byp_hit1_tied", byp_hit1, 0);
        checkOutput("byp_data1_tied", byp_data1, 0);
`endif
        checkOutput("byp_hit2_x0", byp_hit2, 0);
        checkOutput("byp_data2_x0", byp_data2, 0);
        byp_addr2 = 5'd5;
        #1;
        checkOutput("byp_hit2_miss", byp_hit2, 0);
        byp_addr1 = 5'd0;
        byp_addr2 = 5'd0;
        tick();
        bus.rf_stall = 1'b0;
        waitDrain("byp_drained", 10);

        // Reset with entries queued discards them immediately
        bus.rf_stall = 1'b1;
        applyStimulus(1, 5'd10, 32'hA, 1, 5'd11, 32'hB);
        expectWrite(5'd10, 32'hA);
        expectWrite(5'd11, 32'hB);
        tick();
        applyStimulus(0, 0, 0, 1, 5'd12, 32'hC);
        expectWrite(5'd12, 32'hC);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("prerst_count", count, 3);
        bus.rf_stall = 1'b0;
        #1 rst = 1'b1;
        sb.delete();
        #1;
        checkOutput("midrst_count", count, 0);
        checkOutput("midrst_we", bus.we_RF, 0);
        checkOutput("midrst_alu_ready", bus.alu_ready, 1);
        @(posedge clk);
        #3 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        checkOutput("postrst_count", count, 0);

        waitDrain("final_drained", 10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered writeback entries; power of two, minimum 2.
REQ-002 Port clk  in  1  single clock; all state updates on posedge.
REQ-003 Port rst  in  1  reset; asynchronous, active-high.
REQ-004 Port alu_valid  in  1  ALU result offered.
REQ-005 Port alu_rd  in  5  ALU destination register.
REQ-006 Port alu_data  in  32  ALU result.
REQ-007 Port alu_ready  out  1  ALU result accepted this cycle when high with alu_valid.
REQ-008 Port mem_valid  in  1  load result offered.
REQ-009 Port mem_rd  in  5  load destination register.
REQ-010 Port mem_data  in  32  load result.
REQ-011 Port mem_ready  out  1  load result accepted this cycle when high with mem_valid.
REQ-012 Port rf_stall  in  1  register file cannot take a write this cycle.
REQ-013 Port we_RF  out  1  register-file write enable.
REQ-014 Port A3  out  5  register-file write address.
REQ-015 Port WD3  out  32  register-file write data.
REQ-016 Port count  out  $clog2(DEPTH)+1  current occupancy.
REQ-017 Ports byp_addr1, byp_addr2  in  5 each; byp_hit1, byp_hit2  out  1 each; byp_data1, byp_data2  out  32 each; pending-write lookup for the two read ports.

Function
REQ-018 Storage SHALL be a circular FIFO of DEPTH {rd, data} entries, with head/tail pointers and a registered count.
REQ-019 mem_ready SHALL be high iff count <= DEPTH-1.
REQ-020 alu_ready SHALL be high iff count <= DEPTH-2 when mem_valid is high, else iff count <= DEPTH-1.
REQ-021 Ready SHALL use only the registered count; a same-cycle pop SHALL NOT free a slot for a same-cycle push.
REQ-022 When both producers are accepted in one cycle, the mem entry SHALL be enqueued ahead of the alu entry.
REQ-023 An accepted transfer with rd = 0 SHALL complete the handshake but SHALL NOT be stored.
REQ-024 we_RF SHALL equal (count != 0) && !rf_stall; A3/WD3 SHALL present the head entry, or 0 when empty.
REQ-025 Head SHALL pop on the posedge where we_RF is high.
REQ-026 Minimum latency SHALL be one cycle: an entry accepted at edge N drives we_RF in the cycle after edge N.
REQ-027 Pointers SHALL wrap modulo DEPTH; count SHALL update by pushes minus pop, with simultaneous push and pop leaving count unchanged.
REQ-028 Entries SHALL be written to the register file strictly in enqueue order; no reordering or merging.

Reset
REQ-029 Asserting rst SHALL immediately clear pointers and count and discard all entries, including mid-drain.
REQ-030 During reset, we_RF, A3, WD3, count, and all byp_* outputs SHALL be 0; alu_ready and mem_ready SHALL be 1.

Configuration
REQ-031 With WB_BYPASS_EN defined, byp_hitN SHALL be high iff byp_addrN != 0 and a queued entry has rd = byp_addrN; byp_dataN SHALL be the data of the youngest matching entry. This is combinational.
REQ-032 With WB_BYPASS_EN undefined, the byp_* ports SHALL still exist and SHALL be tied to 0.

Structure
REQ-033 Package wb_pkg SHALL hold XLEN = 32, REG_ADDR_W = 5, and typedef wb_entry_t {rd, data}.
REQ-034 FIFO storage and pointer logic SHALL be a sub-module wb_fifo; writeback_queue SHALL hold arbitration, x0 filtering, and bypass.

Verification
REQ-035 Single ALU push, rd = 5, data = 0xDEADBEEF -> next cycle we_RF = 1, A3 = 5, WD3 = 0xDEADBEEF; count returns to 0.
REQ-036 Same-cycle mem (rd = 3, 0x11) and alu (rd = 4, 0x22) pushes into an empty queue -> writes rd 3 then rd 4 on consecutive cycles.
REQ-037 Fill to DEPTH = 4 with rf_stall = 1 -> mem_ready = alu_ready = 0 and count = 4; release stall -> four in-order writes.
REQ-038 Push with rd = 0 -> handshake completes, count stays 0, and we_RF never asserts.
REQ-039 WB_BYPASS_EN defined, rf_stall = 1, queue holds rd 7 = 0x1 then rd 7 = 0x2 -> byp_addr1 = 7 gives hit = 1, data = 0x2; byp_addr2 = 0 gives hit = 0.
REQ-040 Assert rst with 3 entries queued -> same cycle count = 0 and we_RF = 0; no writes occur after release.
